// File: rtl/amo_mem_unit_pkg.sv
// Shared constants and types for the AMO memory-access sequencer.
// AMO_MINMAX_EN (see amo_alu) enables the signed/unsigned min/max funct5 codes.
package amo_mem_unit_pkg;

   localparam logic [4:0] AMO_ADD  = 5'b00000;
   localparam logic [4:0] AMO_SWAP = 5'b00001;
   localparam logic [4:0] AMO_XOR  = 5'b00100;
   localparam logic [4:0] AMO_OR   = 5'b01000;
   localparam logic [4:0] AMO_AND  = 5'b01100;
   localparam logic [4:0] AMO_MIN  = 5'b10000;
   localparam logic [4:0] AMO_MAX  = 5'b10100;
   localparam logic [4:0] AMO_MINU = 5'b11000;
   localparam logic [4:0] AMO_MAXU = 5'b11100;

   localparam logic [1:0] MOP_NONE  = 2'b00;
   localparam logic [1:0] MOP_LOAD  = 2'b01;
   localparam logic [1:0] MOP_STORE = 2'b10;
   localparam logic [1:0] MOP_AMO   = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_READ,
      ST_WRITE,
      ST_DONE
   } state_e;

endpackage

// File: rtl/amo_mem_unit_if.sv
// Data-memory request/ready bus between the AMO sequencer (master) and memory (slave).
interface amo_mem_unit_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ready;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_rdata, mem_ready
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_rdata, mem_ready
   );
endinterface

// File: rtl/amo_mem_unit_alu.sv
// Combinational AMO read-modify-write datapath; flags funct5 codes it does not implement.
// Define AMO_MINMAX_EN to add MIN/MAX/MINU/MAXU.
module amo_alu
   import amo_mem_unit_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0] old,
   input  logic [DATA_W-1:0] src,
   input  logic [4:0]        funct5,
   output logic [DATA_W-1:0] result,
   output logic              legal
);

   // NOTE: every output of a combinational block gets a default first so no path infers a latch.
   always_comb begin
      result = '0;
      legal  = 1'b1;
      case (funct5)
         AMO_ADD:  result = old + src;
         AMO_SWAP: result = src;
         AMO_XOR:  result = old ^ src;
         AMO_OR:   result = old | src;
         AMO_AND:  result = old & src;
`ifdef AMO_MINMAX_EN
         AMO_MIN:  result = ($signed(old) < $signed(src)) ? old : src;
         AMO_MAX:  result = ($signed(old) < $signed(src)) ? src : old;
         AMO_MINU: result = (old < src) ? old : src;
         AMO_MAXU: result = (old < src) ? src : old;
`endif
         default:  legal  = 1'b0;
      endcase
   end

endmodule

// File: rtl/amo_mem_unit.sv
// Load/store/AMO sequencer between the decoder and data memory; stalls the core while busy.
// Build with AMO_MINMAX_EN to accept the min/max AMO codes.
module amo_mem_unit
   import amo_mem_unit_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [1:0]        op,
   input  logic [4:0]        funct5,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   amo_mem_unit_if.master    mem,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] rd_data,
   output logic              fault
);

   state_e            state_q, state_d;
   logic [1:0]        op_q;
   logic [4:0]        funct5_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] old_q;
   logic              accept, reject;
   logic [4:0]        alu_funct5;
   logic [DATA_W-1:0] alu_result;
   logic              alu_legal;

   // In IDLE the live funct5 is checked for legality; afterwards the latched one drives the ALU.
   assign alu_funct5 = (state_q == ST_IDLE) ? funct5 : funct5_q;
   assign busy       = (state_q != ST_IDLE);

   amo_alu #(.DATA_W(DATA_W)) u_alu (
      .old    (mem.mem_rdata),
      .src    (wdata_q),
      .funct5 (alu_funct5),
      .result (alu_result),
      .legal  (alu_legal)
   );

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      reject  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start && op != MOP_NONE) begin
               accept = 1'b1;
               if (addr[1:0] != 2'b00 || (op == MOP_AMO && !alu_legal)) reject  = 1'b1;
               else if (op == MOP_STORE)                                 state_d = ST_WRITE;
               else                                                      state_d = ST_READ;
            end
         end
         ST_READ:  if (mem.mem_ready) state_d = (op_q == MOP_AMO) ? ST_WRITE : ST_DONE;
         ST_WRITE: if (mem.mem_ready) state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q          <= MOP_NONE;
         funct5_q      <= '0;
         wdata_q       <= '0;
         old_q         <= '0;
         mem.mem_req   <= 1'b0;
         mem.mem_we    <= 1'b0;
         mem.mem_addr  <= '0;
         mem.mem_wdata <= '0;
         done          <= 1'b0;
         fault         <= 1'b0;
         rd_data       <= '0;
      end else begin
         done  <= 1'b0;
         fault <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  op_q          <= op;
                  funct5_q      <= funct5;
                  wdata_q       <= wdata;
                  mem.mem_addr  <= {addr[ADDR_W-1:2], 2'b00};
                  mem.mem_wdata <= wdata;
                  if (reject) begin
                     fault <= 1'b1;
                  end else begin
                     mem.mem_req <= 1'b1;
                     mem.mem_we  <= (op == MOP_STORE);
                  end
               end
            end
            ST_READ: begin
               if (mem.mem_ready) begin
                  old_q <= mem.mem_rdata;
                  if (op_q == MOP_AMO) begin
                     // Request stays up so the write follows the read with no gap.
                     mem.mem_we    <= 1'b1;
                     mem.mem_wdata <= alu_result;
                  end else begin
                     mem.mem_req <= 1'b0;
                     rd_data     <= mem.mem_rdata;
                     done        <= 1'b1;
                  end
               end
            end
            ST_WRITE: begin
               if (mem.mem_ready) begin
                  mem.mem_req <= 1'b0;
                  mem.mem_we  <= 1'b0;
                  done        <= 1'b1;
                  if (op_q == MOP_AMO) rd_data <= old_q;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_amo_mem_unit.sv
// Self-checking bench for amo_mem_unit: directed cases plus randomized ops against a memory reference model.
module tb_amo_mem_unit;
   import amo_mem_unit_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [4:0]  funct5 = 5'b0;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic        busy, done, fault;
   logic [31:0] rd_data;

   amo_mem_unit_if #(.ADDR_W(32), .DATA_W(32)) mem_bus ();

   amo_mem_unit #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .op      (op),
      .funct5  (funct5),
      .addr    (addr),
      .wdata   (wdata),
      .mem     (mem_bus),
      .busy    (busy),
      .done    (done),
      .rd_data (rd_data),
      .fault   (fault)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
   endtask

   // Memory seen by the DUT, and an independent reference memory driven by the op-level model.
   logic [31:0] mem_model [logic [31:0]];
   logic [31:0] ref_mem   [logic [31:0]];
   logic [31:0] exp_rd = '0;

   int  wr_cnt = 0, rd_cnt = 0, req_cnt = 0;
   int  hold_cnt = 0;
   bit  ready_rand = 1'b0;
   bit  last_xfer = 1'b0, last_we = 1'b0, pend = 1'b0;
   logic [31:0] last_addr = '0, last_wdata = '0;
   logic        snap_we = 1'b0;
   logic [31:0] snap_addr = '0, snap_wdata = '0;

   initial begin
      mem_bus.mem_ready = 1'b0;
      mem_bus.mem_rdata = '0;
   end

   // Memory responder: commits the previous cycle's transfer, checks request stability, drives ready/rdata.
   always @(negedge clk) begin
      if (last_xfer) begin
         if (last_we) begin
            mem_model[last_addr] = last_wdata;
            wr_cnt++;
         end else begin
            rd_cnt++;
         end
      end
      if (pend && mem_bus.mem_req) begin
         check("stable_addr",  mem_bus.mem_addr,  snap_addr);
         check("stable_we",    {31'b0, mem_bus.mem_we}, {31'b0, snap_we});
         check("stable_wdata", mem_bus.mem_wdata, snap_wdata);
      end
      if (mem_bus.mem_req) req_cnt++;
      if (mem_bus.mem_req && hold_cnt > 0) begin
         mem_bus.mem_ready = 1'b0;
         hold_cnt--;
      end else begin
         mem_bus.mem_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      mem_bus.mem_rdata = mem_model.exists(mem_bus.mem_addr) ? mem_model[mem_bus.mem_addr] : 32'h0;
      last_xfer  = mem_bus.mem_req && mem_bus.mem_ready;
      last_we    = mem_bus.mem_we;
      last_addr  = mem_bus.mem_addr;
      last_wdata = mem_bus.mem_wdata;
      pend       = mem_bus.mem_req && !mem_bus.mem_ready;
      snap_addr  = mem_bus.mem_addr;
      snap_we    = mem_bus.mem_we;
      snap_wdata = mem_bus.mem_wdata;
   end

   function automatic logic [31:0] ref_amo(input logic [4:0] f, input logic [31:0] m,
                                           input logic [31:0] s, output bit ok);
      logic [31:0] r;
      ok = 1'b1;
      r  = '0;
      case (f)
         5'b00000: r = m + s;
         5'b00001: r = s;
         5'b00100: r = m ^ s;
         5'b01000: r = m | s;
         5'b01100: r = m & s;
`ifdef AMO_MINMAX_EN
         5'b10000: r = ($signed(m) <= $signed(s)) ? m : s;
         5'b10100: r = ($signed(m) >= $signed(s)) ? m : s;
         5'b11000: r = (m <= s) ? m : s;
         5'b11100: r = (m >= s) ? m : s;
`endif
         default:  ok = 1'b0;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] ref_rd(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
   endfunction

   function automatic logic [31:0] dut_mem(input logic [31:0] a);
      return mem_model.exists(a) ? mem_model[a] : 32'h0;
   endfunction

   // Issue one op at a negedge, wait (bounded) for done/fault, then compare against the reference model.
   task automatic do_op(input logic [1:0] o, input logic [4:0] f5, input logic [31:0] a,
                        input logic [31:0] w, input int exp_lat);
      logic [31:0] aw, old, nv;
      bit          lg, is_fault;
      int          wr0, rd0, rq0, lat, exp_wr, exp_rdc;
      bit          got_fault;
      aw       = {a[31:2], 2'b00};
      old      = ref_rd(aw);
      nv       = ref_amo(f5, old, w, lg);
      is_fault = (a[1:0] != 2'b00) || (o == MOP_AMO && !lg);
      wr0 = wr_cnt; rd0 = rd_cnt; rq0 = req_cnt;

      start = 1'b1; op = o; funct5 = f5; addr = a; wdata = w;
      @(negedge clk);
      start = 1'b0; op = MOP_NONE;
      lat = 0; got_fault = 1'b0;
      for (int c = 1; c <= 200; c++) begin
         if (done || fault) begin
            lat = c;
            got_fault = fault;
            break;
         end
         @(negedge clk);
      end
      check("timeout", {31'b0, lat != 0}, 32'h1);
      check("fault", {31'b0, got_fault}, {31'b0, is_fault});
      if (exp_lat >= 0) check("latency", lat, exp_lat);
      @(negedge clk);
      check("pulse_done",  {31'b0, done},  32'h0);
      check("pulse_fault", {31'b0, fault}, 32'h0);
      check("busy_after",  {31'b0, busy},  32'h0);

      exp_wr = 0; exp_rdc = 0;
      if (!is_fault) begin
         case (o)
            MOP_LOAD:  begin exp_rd = old; exp_rdc = 1; end
            MOP_STORE: begin ref_mem[aw] = w; exp_wr = 1; end
            default:   begin exp_rd = old; ref_mem[aw] = nv; exp_rdc = 1; exp_wr = 1; end
         endcase
      end
      check("rd_data", rd_data, exp_rd);
      check("writes", wr_cnt - wr0, exp_wr);
      check("reads",  rd_cnt - rd0, exp_rdc);
      check("mem_word", dut_mem(aw), ref_rd(aw));
      if (is_fault) check("no_req", req_cnt - rq0, 0);
   endtask

   logic [4:0] f5_pool [11];
   int         rq_before, wr_before;

   initial begin
      f5_pool = '{AMO_ADD, AMO_SWAP, AMO_XOR, AMO_OR, AMO_AND,
                  AMO_MIN, AMO_MAX, AMO_MINU, AMO_MAXU, 5'b00010, 5'b11111};
      for (int i = 0; i < 16; i++) begin
         logic [31:0] v;
         v = $urandom();
         mem_model[32'h100 + 32'(i * 4)] = v;
         ref_mem[32'h100 + 32'(i * 4)]   = v;
      end

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_req",   {31'b0, mem_bus.mem_req}, 32'h0);
      check("rst_we",    {31'b0, mem_bus.mem_we},  32'h0);
      check("rst_addr",  mem_bus.mem_addr,  32'h0);
      check("rst_wdata", mem_bus.mem_wdata, 32'h0);
      check("rst_busy",  {31'b0, busy},  32'h0);
      check("rst_done",  {31'b0, done},  32'h0);
      check("rst_fault", {31'b0, fault}, 32'h0);
      check("rst_rd",    rd_data, 32'h0);
      rst_n = 1'b1;
      @(negedge clk);

      // op=00 start is ignored
      start = 1'b1; op = MOP_NONE; addr = 32'h100;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("nop_busy", {31'b0, busy}, 32'h0);
         check("nop_done", {31'b0, done}, 32'h0);
         @(negedge clk);
      end

      // Load with ready held low 3 cycles: 4 request cycles, done in cycle 5
      mem_model[32'h100] = 32'hDEADBEEF; ref_mem[32'h100] = 32'hDEADBEEF;
      ready_rand = 1'b0; hold_cnt = 3;
      rq_before = req_cnt;
      do_op(MOP_LOAD, 5'b0, 32'h100, 32'h0, 5);
      check("load_req_cycles", req_cnt - rq_before, 4);
      check("load_rd", rd_data, 32'hDEADBEEF);

      // Store with ready tied high
      do_op(MOP_STORE, 5'b0, 32'h200, 32'h12345678, 2);
      check("store_mem", dut_mem(32'h200), 32'h12345678);
      check("store_rd_kept", rd_data, 32'hDEADBEEF);

      // AMOADD wrap-around
      mem_model[32'h104] = 32'hFFFFFFFF; ref_mem[32'h104] = 32'hFFFFFFFF;
      do_op(MOP_AMO, AMO_ADD, 32'h104, 32'h2, 3);
      check("amoadd_mem", dut_mem(32'h104), 32'h00000001);
      check("amoadd_rd", rd_data, 32'hFFFFFFFF);

      // Misaligned load
      do_op(MOP_LOAD, 5'b0, 32'h102, 32'h0, 1);

      // AMOMIN: legal only with the min/max build
      mem_model[32'h108] = 32'h5; ref_mem[32'h108] = 32'h5;
`ifdef AMO_MINMAX_EN
      do_op(MOP_AMO, AMO_MIN, 32'h108, 32'hFFFFFFFE, 3);
      check("amomin_mem", dut_mem(32'h108), 32'hFFFFFFFE);
      check("amomin_rd", rd_data, 32'h5);
`else
      do_op(MOP_AMO, AMO_MIN, 32'h108, 32'hFFFFFFFE, 1);
      check("amomin_mem", dut_mem(32'h108), 32'h5);
`endif

      // Reset during the READ phase of an AMO
      hold_cnt = 20;
      wr_before = wr_cnt;
      start = 1'b1; op = MOP_AMO; funct5 = AMO_SWAP; addr = 32'h10C; wdata = 32'hA5A5A5A5;
      @(negedge clk);
      start = 1'b0; op = MOP_NONE;
      @(negedge clk);
      check("mid_req_before", {31'b0, mem_bus.mem_req}, 32'h1);
      #2 rst_n = 1'b0;
      #1;
      check("mid_req_dropped", {31'b0, mem_bus.mem_req}, 32'h0);
      check("mid_busy",        {31'b0, busy}, 32'h0);
      @(negedge clk);
      #2 hold_cnt = 0; rst_n = 1'b1;
      exp_rd = 32'h0;
      rq_before = req_cnt;
      repeat (5) @(negedge clk);
      check("post_rst_busy",   {31'b0, busy}, 32'h0);
      check("post_rst_req",    req_cnt - rq_before, 0);
      check("post_rst_writes", wr_cnt - wr_before, 0);
      check("post_rst_mem",    dut_mem(32'h10C), ref_rd(32'h10C));
      check("post_rst_rd",     rd_data, 32'h0);

      // Randomized ops with random memory back-pressure
      ready_rand = 1'b1;
      for (int i = 0; i < 60; i++) begin
         logic [1:0]  ro;
         logic [31:0] ra;
         ro = 2'($urandom_range(1, 3));
         ra = 32'h100 + 32'($urandom_range(0, 15) * 4);
         if ($urandom_range(0, 9) == 0) ra[1:0] = 2'($urandom_range(1, 3));
         do_op(ro, f5_pool[$urandom_range(0, 10)], ra, $urandom(), -1);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
